ram2_write_arbiter: RTL and testbench

- Shares the RAM second write port (wEn2/addr2/dataIn2) between two loaders: requester 0 is the UART program loader, requester 1 is the SD block loader.
- Grants ownership round-robin, with a beat quantum and burst locking.
- Issues at most one registered write per cycle.
- Sits between the loaders and the RAM; the processor's primary RAM port is untouched.

---
 rtl/ram2_write_arbiter_if.sv | 35 +++
 rtl/ram2_write_arbiter.sv | 120 ++++++++++++
 tb/tb_ram2_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram2_write_arbiter_if.sv
// ram2_write_arbiter_if: loader request channels and RAM port-2 write bus
interface ram2_write_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_lock;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_lock;
    logic              req1_ready;
    logic              wEn2;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] dataIn2;
    logic [1:0]        grant;
    logic              wdog_err;

    modport master (
        output req0_valid, req0_addr, req0_data, req0_lock,
        output req1_valid, req1_addr, req1_data, req1_lock,
        input  req0_ready, req1_ready,
        input  wEn2, addr2, dataIn2, grant, wdog_err
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req0_lock,
        input  req1_valid, req1_addr, req1_data, req1_lock,
        output req0_ready, req1_ready,
        output wEn2, addr2, dataIn2, grant, wdog_err
    );
endinterface

// File: rtl/ram2_write_arbiter.sv
// ram2_write_arbiter: round-robin owner of RAM port 2 for UART (0) and SD (1) loaders; ARB_WDOG_EN adds a lock watchdog
module ram2_write_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int QUANTUM     = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input logic clk,
    input logic rst,
    ram2_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int CW = $clog2(QUANTUM + 1);

    state_t            state, state_nx;
    logic              rr_last, rr_last_nx;
    logic [CW-1:0]     beat_cnt, beat_cnt_nx, cnt_inc;
    logic              own, owned, cur_valid, cur_lock, oth_valid, lock_eff, accept, q_exp;
    logic [ADDR_W-1:0] cur_addr, addr_q;
    logic [DATA_W-1:0] cur_data, data_q;
    logic              wen_q;

    assign own       = state == OWN1;
    assign owned     = state != IDLE;
    assign cur_valid = own ? bus.req1_valid : bus.req0_valid;
    assign cur_lock  = own ? bus.req1_lock  : bus.req0_lock;
    assign oth_valid = own ? bus.req0_valid : bus.req1_valid;
    assign cur_addr  = own ? bus.req1_addr  : bus.req0_addr;
    assign cur_data  = own ? bus.req1_data  : bus.req0_data;
    assign accept    = owned & cur_valid;
    assign cnt_inc   = (beat_cnt == CW'(QUANTUM)) ? beat_cnt : beat_cnt + CW'(accept);
    assign q_exp     = cnt_inc == CW'(QUANTUM);

    assign bus.req0_ready = state == OWN0;
    assign bus.req1_ready = state == OWN1;
    assign bus.grant      = {state == OWN1, state == OWN0};
    assign bus.wEn2       = wen_q;
    assign bus.addr2      = addr_q;
    assign bus.dataIn2    = data_q;

`ifdef ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] idle_cnt;
    logic [1:0]    blk;
    logic          wd_fire, err_q;

    assign lock_eff     = cur_lock & ~blk[own];
    assign wd_fire      = owned & lock_eff & ~cur_valid & (idle_cnt == WW'(WDOG_CYCLES - 1));
    assign bus.wdog_err = err_q;

    // Count locked idle cycles of the owner; after a forced release its lock is ignored until dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            blk      <= '0;
            err_q    <= 1'b0;
        end else begin
            idle_cnt <= (state_nx != state || accept) ? '0 :
                        (owned & lock_eff & ~cur_valid) ? idle_cnt + WW'(1) : idle_cnt;
            blk[0]   <= bus.req0_lock & (blk[0] | (wd_fire & ~own));
            blk[1]   <= bus.req1_lock & (blk[1] | (wd_fire & own));
            err_q    <= wd_fire;
        end
    end
`else
    assign lock_eff     = cur_lock;
    assign bus.wdog_err = 1'b0;
`endif

    // Ownership decision: lock beats quantum expiry, which beats owner going quiet
    always_comb begin
        state_nx   = state;
        rr_last_nx = rr_last;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid)
                state_nx = rr_last ? OWN0 : OWN1;
            else if (bus.req0_valid)
                state_nx = OWN0;
            else if (bus.req1_valid)
                state_nx = OWN1;
        end else if (lock_eff) begin
`ifdef ARB_WDOG_EN
            if (wd_fire) begin
                state_nx   = IDLE;
                rr_last_nx = own;
            end
`endif
        end else if (q_exp && oth_valid) begin
            state_nx   = own ? OWN0 : OWN1;
            rr_last_nx = own;
        end else if (!cur_valid) begin
            state_nx   = IDLE;
            rr_last_nx = own;
        end
        beat_cnt_nx = (state_nx != state) ? '0 : cnt_inc;
    end

    // State, round-robin pointer, beat counter and the registered RAM write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            beat_cnt <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_nx;
            rr_last  <= rr_last_nx;
            beat_cnt <= beat_cnt_nx;
            wen_q    <= accept;
            if (accept) begin
                addr_q <= cur_addr;
                data_q <= cur_data;
            end
        end
    end
endmodule

// File: tb/tb_ram2_write_arbiter.sv
// tb_ram2_write_arbiter: directed scenarios plus random traffic against a cycle-level ownership model
module tb_ram2_write_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int Q  = 16;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst;

    ram2_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    ram2_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .QUANTUM(Q), .WDOG_CYCLES(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the port, who went last, beats and idle cycles in this tenure
    int          m_own, m_last, m_cnt, m_idle;
    bit          m_blk [2];
    bit          m_wen, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = 1;
        m_cnt  = 0;
        m_idle = 0;
        m_blk[0] = 0;
        m_blk[1] = 0;
        m_wen  = 0;
        m_err  = 0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_step();
        bit v [2];
        bit l [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int nown, i, o, c;
        v[0] = bus.req0_valid; v[1] = bus.req1_valid;
        l[0] = bus.req0_lock;  l[1] = bus.req1_lock;
        a[0] = bus.req0_addr;  a[1] = bus.req1_addr;
        d[0] = bus.req0_data;  d[1] = bus.req1_data;
        nown  = m_own;
        m_wen = 0;
        m_err = 0;
        if (m_own < 0) begin
            if (v[0] && v[1]) nown = 1 - m_last;
            else if (v[0]) nown = 0;
            else if (v[1]) nown = 1;
        end else begin
            i = m_own;
            o = 1 - i;
            if (v[i]) begin
                m_wen  = 1;
                m_addr = a[i];
                m_data = d[i];
                m_idle = 0;
            end
            c = m_cnt + (v[i] ? 1 : 0);
            if (c > Q) c = Q;
            if (l[i] && !m_blk[i]) begin
`ifdef ARB_WDOG_EN
                if (!v[i]) begin
                    m_idle++;
                    if (m_idle == W) begin
                        nown = -1;
                        m_last = i;
                        m_err = 1;
                        m_blk[i] = 1;
                    end
                end
`endif
            end else if (c >= Q && v[o]) begin
                nown = o;
                m_last = i;
            end else if (!v[i]) begin
                nown = -1;
                m_last = i;
            end
            m_cnt = c;
        end
        for (int j = 0; j < 2; j++) if (!l[j]) m_blk[j] = 0;
        if (nown != m_own) begin
            m_cnt  = 0;
            m_idle = 0;
        end
        m_own = nown;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("grant", bus.grant, {m_own == 1, m_own == 0});
        check("req0_ready", bus.req0_ready, m_own == 0);
        check("req1_ready", bus.req1_ready, m_own == 1);
        check("wEn2", bus.wEn2, m_wen);
        check("addr2", bus.addr2, m_addr);
        check("dataIn2", bus.dataIn2, m_data);
        check("wdog_err", bus.wdog_err, m_err);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive(input bit v0, input bit l0, input bit v1, input bit l1);
        bus.req0_valid = v0;
        bus.req0_lock  = l0;
        bus.req1_valid = v1;
        bus.req1_lock  = l1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        bus.req0_addr = '0;
        bus.req0_data = '0;
        bus.req1_addr = 12'h800;
        bus.req1_data = 32'h5000_0000;
        model_reset();
        #7;
        check("rst_grant", bus.grant, 2'b00);
        check("rst_wEn2", bus.wEn2, 1'b0);
        check("rst_ready0", bus.req0_ready, 1'b0);
        check("rst_ready1", bus.req1_ready, 1'b0);
        check("rst_addr2", bus.addr2, '0);
        check("rst_data2", bus.dataIn2, '0);
        check("rst_wdog", bus.wdog_err, 1'b0);

        // single writer, four beats then idle
        drive(1, 0, 0, 0);
        reset_dut();
        cycle();
        check("sw_grant", bus.grant, 2'b01);
        for (int k = 0; k < 4; k++) begin
            bus.req0_addr = AW'(k);
            bus.req0_data = 32'hA0 + k;
            cycle();
            check("sw_wen", bus.wEn2, 1'b1);
            check("sw_addr", bus.addr2, AW'(k));
            check("sw_data", bus.dataIn2, 32'hA0 + k);
        end
        drive(0, 0, 0, 0);
        cycle();
        check("sw_idle", bus.grant, 2'b00);
        check("sw_wen_end", bus.wEn2, 1'b0);

        // quantum fairness with both loaders busy
        drive(1, 0, 1, 0);
        reset_dut();
        cycle();
        check("q_grant0", bus.grant, 2'b01);
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < Q; k++) begin
                bus.req0_addr = AW'(k);
                bus.req1_addr = AW'(12'h100 + k);
                cycle();
                check("q_wen", bus.wEn2, 1'b1);
            end
            check("q_switch", bus.grant, t == 0 ? 2'b10 : 2'b01);
        end

        // locked 40-beat burst from the SD loader
        drive(0, 0, 1, 1);
        reset_dut();
        cycle();
        check("lk_grant1", bus.grant, 2'b10);
        bus.req0_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.req1_addr = AW'(k);
            cycle();
            check("lk_ready0", bus.req0_ready, 1'b0);
            check("lk_wen", bus.wEn2, 1'b1);
        end
        drive(1, 0, 0, 0);
        cycle();
        check("lk_switch", bus.grant, 2'b01);

        // address wrap
        drive(1, 0, 0, 0);
        bus.req0_addr = 12'hFFF;
        reset_dut();
        cycle();
        cycle();
        check("wr_fff", bus.addr2, 12'hFFF);
        bus.req0_addr = 12'h000;
        cycle();
        check("wr_000", bus.addr2, 12'h000);
        check("wr_wen", bus.wEn2, 1'b1);

        // asynchronous reset with a write pending
        #2 rst = 1'b0;
        #1;
        check("ar_wen", bus.wEn2, 1'b0);
        check("ar_grant", bus.grant, 2'b00);
        check("ar_ready0", bus.req0_ready, 1'b0);
        check("ar_ready1", bus.req1_ready, 1'b0);
        model_reset();
        drive(1, 0, 1, 0);
        #2 rst = 1'b1;
        cycle();
        cycle();
        check("ar_grant01", bus.grant, 2'b01);

        // lock held by an idle owner while the other waits
        drive(0, 0, 1, 1);
        reset_dut();
        cycle();
        drive(1, 0, 0, 1);
`ifdef ARB_WDOG_EN
        for (int k = 0; k < W - 1; k++) begin
            cycle();
            check("wd_hold", bus.grant, 2'b10);
            check("wd_quiet", bus.wdog_err, 1'b0);
        end
        cycle();
        check("wd_pulse", bus.wdog_err, 1'b1);
        check("wd_idle", bus.grant, 2'b00);
        cycle();
        check("wd_grant0", bus.grant, 2'b01);
        check("wd_once", bus.wdog_err, 1'b0);
`else
        for (int k = 0; k < 12; k++) cycle();
        check("nowd_hold", bus.grant, 2'b10);
        check("nowd_err", bus.wdog_err, 1'b0);
`endif

        // random traffic
        drive(0, 0, 0, 0);
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            bus.req0_valid = $urandom_range(3) != 0;
            bus.req1_valid = $urandom_range(3) != 0;
            if ($urandom_range(15) == 0) bus.req0_lock = ~bus.req0_lock;
            if ($urandom_range(15) == 0) bus.req1_lock = ~bus.req1_lock;
            bus.req0_addr = AW'($urandom);
            bus.req1_addr = AW'($urandom);
            bus.req0_data = $urandom;
            bus.req1_data = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
